input_port_requester: RTL and testbench

INPUT_PORT_REQUESTER -- requirements
Module: input_port_requester

---
 rtl/input_port_requester.sv | 133 +++++++++++++
 tb/tb_input_port_requester.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_requester.sv
// Router input port: buffers flits, requests the output port named by each head flit, streams the packet.
// Latency: 3 cycles from push of a head flit to out_valid (head at +1, req at +2, out_valid at +3).
// Backpressure: in_ready drops while the FIFO is full; a pop waits for grant and out_ready.
module input_port_requester #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_flit,
  output logic [4:0]        req,
  input  logic [4:0]        gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_flit,
  input  logic              out_ready,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_t;

  state_t            state;
  logic [2:0]        port;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              head_hd;
  logic              head_tl;
  logic [2:0]        head_dest;
  logic [4:0]        port_mask;
  logic              gnt_hit;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  // Reset is folded in so in_ready is low while held in reset and high on the first cycle out of it.
  assign in_ready  = rst && !full;
  assign push      = in_valid && in_ready;

  assign out_flit  = mem[rd_ptr];
  assign head_hd   = out_flit[DATA_W-1];
  assign head_tl   = out_flit[DATA_W-2];
  assign head_dest = out_flit[DATA_W-3:DATA_W-5];

  // Latched ports 5..7 shift out of the 5-bit mask, so they can never match a grant.
  assign port_mask = 5'd1 << port;
  assign gnt_hit   = |(gnt & port_mask);
  assign out_valid = (state == XFER) && !empty && gnt_hit;

  // Pop source per state: orphan body flits in IDLE, accepted flits in XFER, everything in DROP.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = !empty && !head_hd;
      XFER:    pop = out_valid && out_ready;
      DROP:    pop = !empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Flit storage; data needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  // Packet FSM with registered req (held for the whole packet) and registered err pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      port  <= '0;
      req   <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (!head_hd) begin
              err <= 1'b1;
            end else if (head_dest <= 3'd4) begin
              port  <= head_dest;
              req   <= 5'd1 << head_dest;
              state <= REQ;
            end else begin
              port  <= head_dest;
              err   <= 1'b1;
              state <= DROP;
            end
          end
        end
        REQ: begin
          if (gnt_hit) state <= XFER;
        end
        XFER: begin
          if (pop && head_tl) begin
            req   <= '0;
            state <= IDLE;
          end
        end
        DROP: begin
          if (pop && head_tl) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_requester.sv
// Self-checking bench for input_port_requester: directed cycle table, corner sequences, random packets.
// Latency: checks the 3-cycle head-to-out_valid path cycle by cycle in the table.
// Backpressure: exercises full FIFO, toggling/random out_ready and dropped/random grants.
module tb_input_port_requester;

  typedef logic [31:0] flit_t;

  typedef struct {
    bit         vld;
    flit_t      flit;
    logic [4:0] ereq;
    bit         eov;
    bit         eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  flit_t       in_flit = '0;
  logic [4:0]  req;
  logic [4:0]  gnt = '0;
  logic        out_valid;
  flit_t       out_flit;
  logic        out_ready = 1'b1;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;
  int rs;

  flit_t      src_q[$];
  flit_t      exp_q[$];
  logic [4:0] expreq_q[$];
  int         exp_err;
  vec_t       tbl[13];

  input_port_requester #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .req(req), .gnt(gnt),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input bit h, input bit t, input int d, input int p);
    flit_t f;
    f = '0;
    f[31]    = h;
    f[30]    = t;
    f[29:27] = 3'(d);
    f[26:0]  = 27'(p);
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Packet-level reference: walk the flit stream, keep flits of packets with a legal destination.
  task automatic build_model();
    bit         in_pkt = 1'b0;
    bit         good   = 1'b0;
    logic [4:0] oh     = '0;
    exp_q.delete();
    expreq_q.delete();
    exp_err = 0;
    foreach (src_q[i]) begin
      flit_t f;
      f = src_q[i];
      if (!in_pkt && !f[31]) begin
        exp_err++;
        continue;
      end
      if (!in_pkt) begin
        good = (f[29:27] < 5);
        if (!good) exp_err++;
        oh = 5'd1 << f[29:27];
      end
      if (good) begin
        exp_q.push_back(f);
        expreq_q.push_back(oh);
      end
      in_pkt = !f[30];
    end
  endtask

  task automatic gen_random(input int npkt);
    src_q.delete();
    for (int p = 0; p < npkt; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        src_q.push_back(mk(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom));
      end else begin
        int len = $urandom_range(1, 5);
        int d   = $urandom_range(0, 7);
        for (int k = 0; k < len; k++) src_q.push_back(mk(k == 0, k == len - 1, d, $urandom));
      end
    end
  endtask

  // Push the first n flits of src_q with grants withheld, checking in_ready before each push.
  task automatic prefill(input int n, input string nm);
    gnt = '0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_flit  = src_q[i];
      @(negedge clk);
      chk({nm, " in_ready before push"}, in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Stream src_q (first npre already buffered) and score outputs against the packet model.
  // gmode 0: grant follows req; 1: random grant with noise on unrequested bits.
  // rmode 0: out_ready=1; 1: toggling; 2: random.
  task automatic run(input string nm, input int npre, input int gmode, input int rmode,
                     input bit vgap, input int drop_at, input int max_cyc, output int req_seen);
    int         idx = npre;
    int         n_got = 0;
    int         dmis = 0;
    int         errs = 0;
    int         viol = 0;
    int         drop_left = 3;
    int         quiet = 0;
    logic [4:0] req_prev = '0;
    bit         tail_prev = 1'b0;
    bit         dropping;
    req_seen = 0;
    build_model();
    for (int cyc = 0; cyc < max_cyc && quiet < 4; cyc++) begin
      in_valid = (idx < src_q.size()) && (!vgap || $urandom_range(0, 3) != 0);
      in_flit  = (idx < src_q.size()) ? src_q[idx] : flit_t'($urandom);
      dropping = (drop_at >= 0) && (n_got == drop_at) && (drop_left > 0);
      if (gmode == 0) gnt = req;
      else gnt = (($urandom_range(0, 3) != 0) ? req : 5'd0) | (5'($urandom) & ~req);
      if (dropping) gnt = '0;
      if (rmode == 0)      out_ready = 1'b1;
      else if (rmode == 1) out_ready = cyc[0];
      else                 out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (err) errs++;
      if (req != 0) req_seen++;
      if (!$onehot0(req)) viol++;
      if (out_valid && ((req & gnt) == 0)) viol++;
      if (req_prev != 0 && !tail_prev && req != req_prev) viol++;
      if (dropping) begin
        drop_left--;
        chk({nm, " out_valid during grant drop"}, out_valid, 0);
        chk({nm, " req held during grant drop"}, req, expreq_q[n_got]);
      end
      tail_prev = 1'b0;
      if (out_valid && out_ready) begin
        if (n_got >= exp_q.size()) dmis++;
        else if (out_flit !== exp_q[n_got] || req !== expreq_q[n_got]) dmis++;
        tail_prev = out_flit[30];
        n_got++;
      end
      req_prev = req;
      if (idx == src_q.size() && n_got >= exp_q.size() && errs >= exp_err) quiet++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({nm, " delivered count"}, n_got, exp_q.size());
    chk({nm, " data/order errors"}, dmis, 0);
    chk({nm, " err pulses"}, errs, exp_err);
    chk({nm, " protocol violations"}, viol, 0);
  endtask

  initial begin
    // Reset state and first cycle out of reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req", req, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset err", err, 0);
    chk("reset in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready first cycle after reset", in_ready, 1);
    @(posedge clk); #1;

    // Cycle table: single-flit dest 2 (3-cycle latency), bad dest 7, orphan body flit.
    tbl[0]  = '{1'b1, mk(1, 1, 2, 'h11), 5'b00000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, '0, 5'b00000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, '0, 5'b00100, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, '0, 5'b00100, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, '0, 5'b00000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, mk(1, 1, 7, 'h22), 5'b00000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, '0, 5'b00000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, '0, 5'b00000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, '0, 5'b00000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, mk(0, 0, 3, 'h33), 5'b00000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, '0, 5'b00000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, '0, 5'b00000, 1'b0, 1'b1};
    tbl[12] = '{1'b0, '0, 5'b00000, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      in_valid  = tbl[i].vld;
      in_flit   = tbl[i].flit;
      gnt       = req;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("row%0d req", i), req, tbl[i].ereq);
      chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("row%0d err", i), err, tbl[i].eerr);
      chk($sformatf("row%0d in_ready", i), in_ready, 1);
      if (tbl[i].eov) chk($sformatf("row%0d out_flit", i), out_flit, tbl[0].flit);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // 4-flit packet to W with toggling out_ready.
    src_q = '{mk(1, 0, 4, 'h401), mk(0, 0, 4, 'h402), mk(0, 0, 4, 'h403), mk(0, 1, 4, 'h404)};
    run("pkt4", 0, 0, 1, 1'b0, -1, 100, rs);

    // Fill with grant withheld, reject a fifth flit, then drain in order.
    src_q = '{mk(1, 0, 3, 'h501), mk(0, 0, 3, 'h502), mk(0, 0, 3, 'h503), mk(0, 1, 3, 'h504)};
    prefill(4, "fill");
    in_valid = 1'b1;
    in_flit  = mk(1, 1, 0, 'h5FF);
    @(negedge clk);
    chk("fill in_ready when full", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    run("fill", 4, 0, 0, 1'b0, -1, 100, rs);

    // Bad destination packet is dropped silently apart from one err pulse.
    src_q = '{mk(1, 0, 6, 'h601), mk(0, 0, 6, 'h602), mk(0, 0, 6, 'h603), mk(0, 1, 6, 'h604)};
    run("drop", 0, 0, 0, 1'b0, -1, 100, rs);
    chk("drop req never raised", rs, 0);
    src_q = '{mk(1, 1, 2, 'h6AA)};
    run("after drop", 0, 0, 0, 1'b0, -1, 100, rs);

    // Grant removed for 3 cycles after the first flit of a dest-1 packet.
    src_q = '{mk(1, 0, 1, 'h701), mk(0, 0, 1, 'h702), mk(0, 0, 1, 'h703), mk(0, 1, 1, 'h704)};
    run("gnt drop", 0, 0, 0, 1'b0, 1, 100, rs);

    // Reset mid-transfer with 3 flits buffered, then a fresh packet.
    src_q = '{mk(1, 0, 0, 'h801), mk(0, 0, 0, 'h802), mk(0, 0, 0, 'h803)};
    prefill(3, "rst");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gnt = req;
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("rst reached xfer", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    gnt = '0;
    #1;
    chk("rst mid-packet req", req, 0);
    chk("rst mid-packet out_valid", out_valid, 0);
    chk("rst mid-packet in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready after mid-packet reset", in_ready, 1);
    @(posedge clk); #1;
    src_q = '{mk(1, 1, 4, 'h8AA)};
    run("after reset", 0, 0, 0, 1'b0, -1, 100, rs);

    // Random packet streams against the packet-level model.
    for (int r = 0; r < 2; r++) begin
      gen_random(50);
      run($sformatf("random%0d", r), 0, 1 - r, 2 - r, 1'b1, -1, 5000, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
